// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// One shared 64-bit adder performs the trial subtraction on every iteration.

module adder64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};
endmodule

module div_seq #(
  parameter int XLEN     = 64,
  parameter int ITER_W64 = 64,
  parameter int ITER_W32 = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(ITER_W64 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_signed;
  logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, min_neg;
  logic              a_neg, b_neg, ovf;
  logic [XLEN-1:0]   rem_sh, diff, q_fin, r_fin;
  logic              cout;

  function automatic logic [XLEN-1:0] sext_w(input logic w, input logic [XLEN-1:0] x);
    return w ? {{32{x[31]}}, x[31:0]} : x;
  endfunction

  // Operand conditioning for PREP: W forms look only at the low 32 bits.
  assign is_signed = ~op_q[0];
  assign ext_a     = word_q ? (is_signed ? {{32{a_q[31]}}, a_q[31:0]} : {32'd0, a_q[31:0]}) : a_q;
  assign ext_b     = word_q ? (is_signed ? {{32{b_q[31]}}, b_q[31:0]} : {32'd0, b_q[31:0]}) : b_q;
  assign a_neg     = is_signed & ext_a[XLEN-1];
  assign b_neg     = is_signed & ext_b[XLEN-1];
  assign mag_a     = a_neg ? ~ext_a + 64'd1 : ext_a;
  assign mag_b     = b_neg ? ~ext_b + 64'd1 : ext_b;
  assign min_neg   = word_q ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign ovf       = is_signed && (ext_a == min_neg) && (ext_b == '1);

  // The partial remainder before the shift never exceeds 63 bits, so the
  // adder carry alone decides whether the trial subtraction succeeds.
  assign rem_sh = {rem_q[XLEN-2:0], quo_q[XLEN-1]};

  adder64 u_add (
    .a    (rem_sh),
    .b    (~dvs_q),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  assign q_fin = qneg_q ? ~quo_q + 64'd1 : quo_q;
  assign r_fin = rneg_q ? ~rem_q + 64'd1 : rem_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path can infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_PREP;
          op_d    = op;
          word_d  = word;
          a_d     = dividend;
          b_d     = divisor;
        end
      end
      S_PREP: begin
        if (ext_b == '0) begin
          result_d = sext_w(word_q, op_q[1] ? ext_a : '1);
          state_d  = S_DONE;
        end else if (ovf) begin
          result_d = sext_w(word_q, op_q[1] ? '0 : ext_a);
          state_d  = S_DONE;
        end else begin
          rem_d   = '0;
          quo_d   = word_q ? {mag_a[31:0], 32'd0} : mag_a;
          dvs_d   = mag_b;
          cnt_d   = word_q ? CNT_W'(ITER_W32) : CNT_W'(ITER_W64);
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = cout ? diff : rem_sh;
        quo_d = {quo_q[XLEN-2:0], cout};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = sext_w(word_q, op_q[1] ? r_fin : q_fin);
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a request arriving in IDLE.
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      word_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: vector table with a result/latency scoreboard, plus
// hand-written sequences for back-pressure, flush and mid-operation reset.

module tb_div_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        word;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  div_seq dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word      (word),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
  localparam int NV = 20;

  vec_t vecs [NV];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  int   t_acc  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request from IDLE; returns one step after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
    op = o; word = w; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else begin @(posedge clock); #1; end
    end
  endtask

  task automatic run_vec(input int idx);
    exp_t e;
    bit   seen;
    check($sformatf("v%0d in_ready", idx), {63'd0, in_ready}, 64'd1);
    sb_q.push_back('{vecs[idx].exp, vecs[idx].lat});
    issue(vecs[idx].op, vecs[idx].word, vecs[idx].a, vecs[idx].b);
    wait_valid(seen);
    e = sb_q.pop_front();
    check($sformatf("v%0d out_valid seen", idx), {63'd0, seen}, 64'd1);
    if (seen) begin
      check($sformatf("v%0d result", idx), result, e.res);
      check($sformatf("v%0d latency", idx), 64'(cyc - t_acc + 1), 64'(e.lat));
      check($sformatf("v%0d in_ready in DONE", idx), {63'd0, in_ready}, 64'd0);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    bit seen;
    bit any_valid;

    vecs[0]  = '{DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 67};
    vecs[1]  = '{REMU, 1'b0, 64'd100, 64'd7, 64'd2, 67};
    vecs[2]  = '{DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67};
    vecs[3]  = '{REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    vecs[4]  = '{DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[5]  = '{REM,  1'b0, 64'h1234, 64'd0, 64'h1234, 2};
    vecs[6]  = '{DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2};
    vecs[7]  = '{REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2};
    vecs[8]  = '{DIV,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 35};
    vecs[9]  = '{REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd16, 64'h0000_0000_0000_000F, 35};
    vecs[10] = '{DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 67};
    vecs[11] = '{REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 67};
    vecs[12] = '{DIV,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 67};
    vecs[13] = '{REM,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 67};
    vecs[14] = '{DIVU, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[15] = '{REMU, 1'b1, 64'h0000_0001_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 2};
    vecs[16] = '{DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2};
    vecs[17] = '{REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 35};
    vecs[18] = '{DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd3, 64'h0000_0000_5555_5555, 35};
    vecs[19] = '{DIVU, 1'b1, 64'hFFFF_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 35};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; word = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset result",    result, 64'd0);
    check("reset busy",      {63'd0, busy}, 64'd0);
    check("reset in_ready",  {63'd0, in_ready}, 64'd1);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-pressure: result and flags must hold while out_ready is low.
    out_ready = 1'b0;
    issue(DIVU, 1'b0, 64'd100, 64'd7);
    wait_valid(seen);
    check("hold out_valid seen", {63'd0, seen}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d out_valid", k), {63'd0, out_valid}, 64'd1);
      check($sformatf("hold%0d result", k), result, 64'd14);
      check($sformatf("hold%0d in_ready", k), {63'd0, in_ready}, 64'd0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("release out_valid", {63'd0, out_valid}, 64'd0);
    check("release in_ready",  {63'd0, in_ready}, 64'd1);

    // Flush during cycle T+20 of a 64-bit op: IDLE at T+21, never any output.
    out_ready = 1'b1;
    issue(DIVU, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(posedge clock);
    #1;
    check("pre-flush busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush busy",     {63'd0, busy}, 64'd0);
    check("flush in_ready", {63'd0, in_ready}, 64'd1);
    any_valid = 1'b0;
    repeat (80) begin
      @(posedge clock); #1;
      any_valid |= out_valid;
    end
    check("flush no out_valid", {63'd0, any_valid}, 64'd0);

    // Reset low during cycle T+10: outputs return to reset values at once.
    issue(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 64'd5);
    repeat (9) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst result",    result, 64'd0);
    check("midrst busy",      {63'd0, busy}, 64'd0);
    check("midrst in_ready",  {63'd0, in_ready}, 64'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    any_valid = 1'b0;
    repeat (80) begin
      @(posedge clock); #1;
      any_valid |= out_valid;
    end
    check("midrst no out_valid", {63'd0, any_valid}, 64'd0);

    // Flush and in_valid together in IDLE: the request is dropped.
    op = DIVU; word = 1'b0; dividend = 64'd9; divisor = 64'd3;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush+req busy",     {63'd0, busy}, 64'd0);
    check("flush+req in_ready", {63'd0, in_ready}, 64'd1);
    any_valid = 1'b0;
    repeat (10) begin
      @(posedge clock); #1;
      any_valid |= out_valid;
    end
    check("flush+req no out_valid", {63'd0, any_valid}, 64'd0);

    // The unit still works normally after the aborts.
    run_vec(2);
    run_vec(9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
